// File: rtl/seg_scan_if.sv
// Bundle of the value-producer inputs and the decoder/anode outputs of the
// 7-segment scan controller. The producer side drives the buffer inputs and
// observes the scan outputs; the controller side is the reverse.
interface seg_scan_if #(
    parameter int N_DIGITS = 4
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                  enable;
    logic                  load;
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blank_mask;
    logic [3:0]            bcd_sel;
    logic [N_DIGITS-1:0]   an;
    logic                  dp;
    logic [IDX_W-1:0]      digit_idx;
    logic                  frame_done;

    modport master (
        output enable, load, value, dp_in, blank_mask,
        input  bcd_sel, an, dp, digit_idx, frame_done
    );

    modport slave (
        input  enable, load, value, dp_in, blank_mask,
        output bcd_sel, an, dp, digit_idx, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller. One digit is selected per slot;
// each slot opens with a blanking interval (all anodes off) followed by the
// lit interval. The displayed value is double-buffered: loads go to a pending
// buffer that is copied to the display buffer only at a frame boundary, so a
// frame is never torn. All outputs are registered and computed from the
// next-state values so they line up exactly with the state they describe.
module seg_scan_ctrl #(
    parameter int N_DIGITS       = 4,
    parameter int SLOT_CYCLES    = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter int AN_ACTIVE_HIGH = 0
) (
    input  logic       clk,
    input  logic       reset,
    seg_scan_if.slave  bus
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(SLOT_CYCLES + 1);

    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]    SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF     = (AN_ACTIVE_HIGH != 0) ? '0 : '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // Scan state
    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  slot_cnt_reg, slot_cnt_next;
    logic [IDX_W-1:0]  digit_idx_reg, digit_idx_next;
    logic              boundary;

    // Display (committed) and pending buffers
    logic [4*N_DIGITS-1:0] disp_value_reg, disp_value_next;
    logic [N_DIGITS-1:0]   disp_dp_reg, disp_dp_next;
    logic [N_DIGITS-1:0]   disp_blank_reg, disp_blank_next;
    logic [4*N_DIGITS-1:0] pend_value_reg, pend_value_next;
    logic [N_DIGITS-1:0]   pend_dp_reg, pend_dp_next;
    logic [N_DIGITS-1:0]   pend_blank_reg, pend_blank_next;
    logic                  pend_valid_reg, pend_valid_next;
    logic                  commit;

    // Registered outputs and their next values
    logic [N_DIGITS-1:0] an_reg, an_next;
    logic [3:0]          bcd_sel_reg, bcd_sel_next;
    logic                dp_reg, dp_next;
    logic                frame_done_reg, frame_done_next;
    logic [N_DIGITS-1:0] an_on_next;
    logic [3:0]          nib_next [N_DIGITS];

    // Next scan position; boundary marks a frame start (wrap to digit 0 or idle exit)
    always_comb begin
        state_next     = state_reg;
        slot_cnt_next  = slot_cnt_reg;
        digit_idx_next = digit_idx_reg;
        boundary       = 1'b0;
        if (!bus.enable) begin
            state_next     = IDLE;
            slot_cnt_next  = '0;
            digit_idx_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next     = BLANK;
                    slot_cnt_next  = '0;
                    digit_idx_next = '0;
                    boundary       = 1'b1;
                end
                BLANK: begin
                    slot_cnt_next = slot_cnt_reg + 1'b1;
                    if (slot_cnt_reg == BLANK_LAST) begin
                        state_next = SHOW;
                    end
                end
                SHOW: begin
                    if (slot_cnt_reg == SLOT_LAST) begin
                        state_next    = BLANK;
                        slot_cnt_next = '0;
                        if (digit_idx_reg == LAST_IDX) begin
                            digit_idx_next = '0;
                            boundary       = 1'b1;
                        end else begin
                            digit_idx_next = digit_idx_reg + 1'b1;
                        end
                    end else begin
                        slot_cnt_next = slot_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next     = IDLE;
                    slot_cnt_next  = '0;
                    digit_idx_next = '0;
                end
            endcase
        end
    end

    // Buffer update: load writes pending; a boundary commit takes a same-cycle load directly
    always_comb begin
        commit          = boundary && (pend_valid_reg || bus.load);
        pend_value_next = bus.load ? bus.value      : pend_value_reg;
        pend_dp_next    = bus.load ? bus.dp_in      : pend_dp_reg;
        pend_blank_next = bus.load ? bus.blank_mask : pend_blank_reg;
        pend_valid_next = commit ? 1'b0 : (bus.load || pend_valid_reg);
        disp_value_next = commit ? pend_value_next : disp_value_reg;
        disp_dp_next    = commit ? pend_dp_next    : disp_dp_reg;
        disp_blank_next = commit ? pend_blank_next : disp_blank_reg;
    end

    // Per-digit nibble split and anode decode against the next scan position
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign nib_next[gi]   = disp_value_next[4*gi +: 4];
            assign an_on_next[gi] = (state_next == SHOW) &&
                                    (digit_idx_next == IDX_W'(gi)) &&
                                    !disp_blank_next[gi];
        end
    endgenerate

    // Output values for the cycle after the coming edge
    always_comb begin
        an_next         = (AN_ACTIVE_HIGH != 0) ? an_on_next : ~an_on_next;
        bcd_sel_next    = (state_next == IDLE) ? 4'd0 : nib_next[digit_idx_next];
        dp_next         = (state_next != IDLE) && disp_dp_next[digit_idx_next];
        frame_done_next = (state_next == SHOW) && (slot_cnt_next == SLOT_LAST) &&
                          (digit_idx_next == LAST_IDX);
    end

    // Scan FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            slot_cnt_reg   <= '0;
            digit_idx_reg  <= '0;
            an_reg         <= AN_OFF;
            bcd_sel_reg    <= 4'd0;
            dp_reg         <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            slot_cnt_reg   <= slot_cnt_next;
            digit_idx_reg  <= digit_idx_next;
            an_reg         <= an_next;
            bcd_sel_reg    <= bcd_sel_next;
            dp_reg         <= dp_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Pending and display buffers; reset leaves every digit forced dark
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_value_reg <= '0;
            disp_dp_reg    <= '0;
            disp_blank_reg <= '1;
            pend_value_reg <= '0;
            pend_dp_reg    <= '0;
            pend_blank_reg <= '1;
            pend_valid_reg <= 1'b0;
        end else begin
            disp_value_reg <= disp_value_next;
            disp_dp_reg    <= disp_dp_next;
            disp_blank_reg <= disp_blank_next;
            pend_value_reg <= pend_value_next;
            pend_dp_reg    <= pend_dp_next;
            pend_blank_reg <= pend_blank_next;
            pend_valid_reg <= pend_valid_next;
        end
    end

    assign bus.an         = an_reg;
    assign bus.bcd_sel    = bcd_sel_reg;
    assign bus.dp         = dp_reg;
    assign bus.digit_idx  = digit_idx_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed test-plan scenarios followed by random
// traffic, all outputs compared every cycle against a time-based model.
module tb_seg_scan_ctrl;
    localparam int N     = 4;
    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = N * SLOT;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg_scan_if #(.N_DIGITS(N)) bus ();

    seg_scan_ctrl #(
        .N_DIGITS      (N),
        .SLOT_CYCLES   (SLOT),
        .BLANK_CYCLES  (BLANK),
        .AN_ACTIVE_HIGH(0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: t = position within the frame (-1 when dark/idle), plus buffers
    int          t = -1;
    logic [15:0] m_val, p_val;
    logic [3:0]  m_dp, m_blank, p_dp, p_blank;
    bit          m_pv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // One clock: advance the model on the sampled inputs, then compare all outputs
    task automatic step();
        logic        r, e, l;
        logic [15:0] v, tmp;
        logic [3:0]  d, b;
        bit          boundary;
        int          dg, pos;
        logic [3:0]  e_an, e_bcd;
        logic        e_dp, e_fd;
        r = reset; e = bus.enable; l = bus.load;
        v = bus.value; d = bus.dp_in; b = bus.blank_mask;
        @(posedge clk);
        #1;
        if (r) begin
            t = -1;
            m_val = '0; m_dp = '0; m_blank = '1;
            p_val = '0; p_dp = '0; p_blank = '1;
            m_pv = 1'b0;
        end else begin
            boundary = 1'b0;
            if (!e) begin
                t = -1;
            end else if (t < 0) begin
                t = 0;
                boundary = 1'b1;
            end else begin
                t = (t + 1) % FRAME;
                boundary = (t == 0);
            end
            if (l) begin
                p_val = v; p_dp = d; p_blank = b; m_pv = 1'b1;
            end
            if (boundary && m_pv) begin
                m_val = p_val; m_dp = p_dp; m_blank = p_blank; m_pv = 1'b0;
            end
        end
        if (t < 0) begin
            dg = 0; e_an = 4'hF; e_bcd = 4'h0; e_dp = 1'b0; e_fd = 1'b0;
        end else begin
            dg  = t / SLOT;
            pos = t % SLOT;
            tmp = m_val >> (4 * dg);
            e_bcd = tmp[3:0];
            e_dp  = m_dp[dg];
            e_an  = (pos >= BLANK && !m_blank[dg]) ? (4'hF & ~(4'b0001 << dg)) : 4'hF;
            e_fd  = (t == FRAME - 1);
        end
        check("an", 32'(bus.an), 32'(e_an));
        check("bcd_sel", 32'(bus.bcd_sel), 32'(e_bcd));
        check("dp", 32'(bus.dp), 32'(e_dp));
        check("digit_idx", 32'(bus.digit_idx), 32'(dg));
        check("frame_done", 32'(bus.frame_done), 32'(e_fd));
    endtask

    task automatic step_to(input int target);
        int n = 0;
        while (t != target && n < 200) begin
            step();
            n++;
        end
        if (t != target) check("step_to_timeout", 32'(t), 32'(target));
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        bus.load = 1'b1; bus.value = v; bus.dp_in = d; bus.blank_mask = b;
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0; bus.load = 1'b0;
        bus.value = '0; bus.dp_in = '0; bus.blank_mask = '0;
        step(); step();
        check("rst_an", 32'(bus.an), 32'h0000000F);
        check("rst_bcd", 32'(bus.bcd_sel), 32'h0);
        reset = 1'b0;

        // Basic scan
        pulse_load(16'h4321, 4'b0000, 4'b0000);
        bus.enable = 1'b1;
        step();
        check("c0_an", 32'(bus.an), 32'hF);
        step_to(2);
        check("c2_an", 32'(bus.an), 32'b1110);
        check("c2_bcd", 32'(bus.bcd_sel), 32'h1);
        step_to(10);
        check("c10_an", 32'(bus.an), 32'b1101);
        check("c10_bcd", 32'(bus.bcd_sel), 32'h2);

        // Tear-free mid-frame load
        step_to(12);
        pulse_load(16'h9999, 4'b0000, 4'b0000);
        step_to(18);
        check("tear_bcd", 32'(bus.bcd_sel), 32'h3);
        step_to(31);
        check("c31_fd", 32'(bus.frame_done), 32'h1);
        step_to(2);
        check("f1_bcd", 32'(bus.bcd_sel), 32'h9);

        // Last load wins, including one on the commit cycle
        step_to(20);
        pulse_load(16'hAAAA, 4'b0000, 4'b0000);
        step_to(31);
        pulse_load(16'h5555, 4'b0000, 4'b0000);
        step_to(10);
        check("lastwin_bcd", 32'(bus.bcd_sel), 32'h5);

        // Load exactly on the commit cycle alone
        step_to(31);
        pulse_load(16'h1234, 4'b0000, 4'b0000);
        step_to(2);
        check("c31load_bcd", 32'(bus.bcd_sel), 32'h4);

        // Blanking mask and decimal point
        step_to(5);
        pulse_load(16'h8765, 4'b0010, 4'b1000);
        step_to(31);
        step_to(10);
        check("dp_d1", 32'(bus.dp), 32'h1);
        check("an_d1", 32'(bus.an), 32'b1101);
        step_to(26);
        check("an_d3_blank", 32'(bus.an), 32'hF);
        check("dp_d3", 32'(bus.dp), 32'h0);

        // Disable mid-frame, then re-enable
        step_to(13);
        bus.enable = 1'b0;
        step();
        check("dis_an", 32'(bus.an), 32'hF);
        check("dis_idx", 32'(bus.digit_idx), 32'h0);
        step(); step(); step();
        bus.enable = 1'b1;
        step();
        check("reen_an", 32'(bus.an), 32'hF);
        step_to(2);
        check("reen_an2", 32'(bus.an), 32'b1110);
        check("reen_bcd", 32'(bus.bcd_sel), 32'h5);

        // Reset mid-frame: everything dark until the next load
        step_to(13);
        reset = 1'b1;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        reset = 1'b0;
        check("rst2_bcd", 32'(bus.bcd_sel), 32'h0);
        step_to(2);
        check("rst2_an", 32'(bus.an), 32'hF);
        step_to(10);
        check("rst2_an10", 32'(bus.an), 32'hF);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 299) == 0);
            bus.enable     = ($urandom_range(0, 79) != 0);
            bus.load       = ($urandom_range(0, 11) == 0);
            bus.value      = 16'($urandom);
            bus.dp_in      = 4'($urandom);
            bus.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
